// File: rtl/axis_chop_pkg.sv
// Shared types for the axis_chop burst chopper and its output register slice.
package axis_chop_pkg;

  // Occupancy of the two-entry output slice.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axis_skid.sv
// Two-entry register slice: a main output register plus a skid register that
// catches the beat accepted while the downstream stalls, so in_ready can be a flop.
module axis_skid
  import axis_chop_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q;
  logic             in_hs, out_hs;
  logic             load_main, load_skid, pop_skid;

  assign in_hs  = in_valid & ready_q;
  assign out_hs = (state_q != SKID_EMPTY) & out_ready;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_hs) begin
          state_d   = SKID_ONE;
          load_main = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_hs && out_hs) begin
          load_main = 1'b1;
        end else if (in_hs) begin
          state_d   = SKID_TWO;
          load_skid = 1'b1;
        end else if (out_hs) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_hs) begin
          state_d  = SKID_ONE;
          pop_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) state_d = SKID_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the data registers are reset too, because the reset value of out_data is visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_TWO);
      if (load_main)     main_q <= in_data;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/axis_chop.sv
// AXI4-Stream burst chopper: forwards a packet truncated to min(length_i, MAXLEN)
// beats, marking the last forwarded beat with m_tlast.
module axis_chop
  import axis_chop_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int MAXLEN = 64,
  parameter  bit BYPASS = 1'b0,
  localparam int LBITS  = $clog2(MAXLEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active_i,
  input  logic [LBITS-1:0] length_i,
  output logic             final_o,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata
);

  logic [LBITS-1:0] lim;
  logic [LBITS-1:0] cnt;
  logic             done;
  logic             open;
  logic             fwd_ok;
  logic             beat_last;
  logic             hs;

  assign lim       = (length_i > LBITS'(MAXLEN)) ? LBITS'(MAXLEN) : length_i;
  assign open      = active_i & ~done;
  assign fwd_ok    = (lim != '0);
  // Widened by one bit so cnt + 1 cannot wrap when cnt sits at MAXLEN.
  assign final_o   = open & (~fwd_ok | (({1'b0, cnt} + (LBITS + 1)'(1)) >= {1'b0, lim}));
  assign beat_last = s_tlast | final_o;
  assign hs        = s_tvalid & s_tready;

  // done freezes the counter, so it never wraps within a transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!active_i) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (hs) begin
      cnt <= cnt + LBITS'(1);
      if (beat_last) done <= 1'b1;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign s_tready = m_tready & open;
      assign m_tvalid = s_tvalid & open & fwd_ok;
      assign m_tdata  = s_tdata;
      assign m_tlast  = beat_last;
    end else begin : g_skid
      logic             skid_ready;
      logic             skid_valid;
      logic [WIDTH:0]   skid_data;

      // Zero-length beats are accepted upstream but never enter the slice.
      axis_skid #(
        .WIDTH (WIDTH + 1)
      ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (~active_i),
        .in_valid  (s_tvalid & open & fwd_ok),
        .in_ready  (skid_ready),
        .in_data   ({beat_last, s_tdata}),
        .out_valid (skid_valid),
        .out_ready (m_tready),
        .out_data  (skid_data)
      );

      assign s_tready           = skid_ready & open;
      assign m_tvalid           = skid_valid & active_i;
      assign {m_tlast, m_tdata} = skid_data;
    end
  endgenerate

endmodule

// File: tb/tb_axis_chop.sv
// Directed testbench for axis_chop in registered (skid) mode.
module tb_axis_chop;

  localparam int WIDTH  = 8;
  localparam int MAXLEN = 64;
  localparam int LBITS  = $clog2(MAXLEN + 1);

  logic             clock;
  logic             reset;
  logic             active_i;
  logic [LBITS-1:0] length_i;
  logic             final_o;
  logic             s_tvalid, s_tready, s_tlast;
  logic [WIDTH-1:0] s_tdata;
  logic             m_tvalid, m_tready, m_tlast;
  logic [WIDTH-1:0] m_tdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] out_d[$];
  logic             out_l[$];
  int               out_c[$];
  logic             in_final[$];
  int               first_in;
  int               stall_bad;

  axis_chop #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .BYPASS(1'b0)) dut (
    .clock    (clock),
    .reset    (reset),
    .active_i (active_i),
    .length_i (length_i),
    .final_o  (final_o),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one transfer for a fixed number of cycles and records both handshakes.
  // rmode: 0 = m_tready always high, 1 = random, 2 = always low.
  task automatic run_xfer(input int len, input int npkt, input int base,
                          input int rmode, input int budget);
    int idx;
    bit stalled;
    logic [WIDTH-1:0] held_d;
    logic held_l;
    out_d.delete(); out_l.delete(); out_c.delete(); in_final.delete();
    idx = 0; first_in = -1; stall_bad = 0; stalled = 0;
    held_d = '0; held_l = 1'b0;
    length_i = LBITS'(len);
    active_i = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      s_tvalid = (idx < npkt);
      s_tdata  = WIDTH'(base + idx);
      s_tlast  = (idx == npkt - 1);
      m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      if (stalled && (!m_tvalid || m_tdata !== held_d || m_tlast !== held_l)) stall_bad++;
      stalled = m_tvalid & ~m_tready;
      held_d  = m_tdata;
      held_l  = m_tlast;
      if (s_tvalid && s_tready) begin
        in_final.push_back(final_o);
        if (first_in < 0) first_in = c;
        idx++;
      end
      if (m_tvalid && m_tready) begin
        out_d.push_back(m_tdata);
        out_l.push_back(m_tlast);
        out_c.push_back(c);
      end
    end
  endtask

  task automatic end_xfer();
    @(posedge clock); #1;
    active_i = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({m_tvalid, s_tready, final_o, m_tlast} !== 4'b0000 || m_tdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: got v/r/f/l=%b%b%b%b data=%h, want 0000 data=00",
               m_tvalid, s_tready, final_o, m_tlast, m_tdata);
    end
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Exact-length packet: 18 beats, streaming, tlast and final_o on the 18th.
  task automatic test_full_packet();
    run_xfer(18, 18, 8'h01, 0, 25);
    tests_run++;
    if (out_d.size() != 18 || in_final.size() != 18) begin
      tests_failed++;
      $display("FAIL full_count: out=%0d in=%0d, want 18/18", out_d.size(), in_final.size());
    end
    for (int k = 0; k < out_d.size() && k < 18; k++) begin
      tests_run++;
      if (out_d[k] !== WIDTH'(8'h01 + k) || out_l[k] !== (k == 17) ||
          out_c[k] != first_in + 1 + k || in_final[k] !== (k == 17)) begin
        tests_failed++;
        $display("FAIL full_beat%0d: data=%h last=%b cyc=%0d final=%b, want %h %b %0d %b",
                 k, out_d[k], out_l[k], out_c[k], in_final[k],
                 WIDTH'(8'h01 + k), (k == 17), first_in + 1 + k, (k == 17));
      end
    end
    end_xfer();
  endtask

  // length 8 on an 18-byte source: chopped after beat 8, s_tready stays low.
  task automatic test_chop();
    run_xfer(8, 18, 8'h20, 0, 20);
    tests_run++;
    if (out_d.size() != 8 || in_final.size() != 8 || s_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL chop_count: out=%0d in=%0d s_tready=%b, want 8/8/0",
               out_d.size(), in_final.size(), s_tready);
    end
    for (int k = 0; k < out_d.size() && k < 8; k++) begin
      tests_run++;
      if (out_d[k] !== WIDTH'(8'h20 + k) || out_l[k] !== (k == 7) || in_final[k] !== (k == 7)) begin
        tests_failed++;
        $display("FAIL chop_beat%0d: data=%h last=%b final=%b, want %h %b %b",
                 k, out_d[k], out_l[k], in_final[k], WIDTH'(8'h20 + k), (k == 7), (k == 7));
      end
    end
    end_xfer();
  endtask

  // length 72 saturates to 64 on a 100-byte source.
  task automatic test_saturate();
    int bad;
    run_xfer(72, 100, 8'h00, 0, 80);
    tests_run++;
    if (out_d.size() != 64 || in_final.size() != 64) begin
      tests_failed++;
      $display("FAIL sat_count: out=%0d in=%0d, want 64/64", out_d.size(), in_final.size());
    end
    bad = 0;
    for (int k = 0; k < out_d.size(); k++)
      if (out_d[k] !== WIDTH'(k) || out_l[k] !== (k == 63)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL sat_beats: %0d bad beats, want 0", bad);
    end
    end_xfer();
  endtask

  // Zero length: one beat consumed with final_o, nothing forwarded.
  task automatic test_zero_length();
    run_xfer(0, 5, 8'h90, 0, 10);
    tests_run++;
    if (in_final.size() != 1 || out_d.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_count: in=%0d out=%0d, want 1/0", in_final.size(), out_d.size());
    end
    tests_run++;
    if (in_final.size() < 1 || in_final[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_final: final_o during handshake not seen high, want 1");
    end
    end_xfer();
  endtask

  // Random backpressure: order, no loss, stability while stalled.
  task automatic test_backpressure();
    int bad;
    run_xfer(64, 34, 8'h50, 1, 200);
    tests_run++;
    if (out_d.size() != 34 || stall_bad != 0) begin
      tests_failed++;
      $display("FAIL bp_count: out=%0d stall_changes=%0d, want 34/0", out_d.size(), stall_bad);
    end
    bad = 0;
    for (int k = 0; k < out_d.size(); k++)
      if (out_d[k] !== WIDTH'(8'h50 + k) || out_l[k] !== (k == 33)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_order: %0d bad beats, want 0", bad);
    end
    end_xfer();
  endtask

  // Abort mid-packet, then a fresh 4-beat transfer.
  task automatic test_abort();
    int seen;
    run_xfer(64, 20, 8'h40, 2, 6);
    tests_run++;
    if (m_tvalid !== 1'b1 || out_d.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_pre: m_tvalid=%b out=%0d, want 1/0", m_tvalid, out_d.size());
    end
    @(posedge clock); #1;
    active_i = 1'b0;
    s_tvalid = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_drop: m_tvalid=%b s_tready=%b, want 0/0", m_tvalid, s_tready);
    end
    m_tready = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (m_tvalid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_drain: %0d valid cycles after abort, want 0", seen);
    end
    run_xfer(4, 10, 8'hA0, 0, 10);
    tests_run++;
    if (out_d.size() != 4 || in_final.size() != 4) begin
      tests_failed++;
      $display("FAIL restart_count: out=%0d in=%0d, want 4/4", out_d.size(), in_final.size());
    end
    for (int k = 0; k < out_d.size() && k < 4; k++) begin
      tests_run++;
      if (out_d[k] !== WIDTH'(8'hA0 + k) || out_l[k] !== (k == 3)) begin
        tests_failed++;
        $display("FAIL restart_beat%0d: data=%h last=%b, want %h %b",
                 k, out_d[k], out_l[k], WIDTH'(8'hA0 + k), (k == 3));
      end
    end
    end_xfer();
  endtask

  // Asynchronous reset while the output holds a beat.
  task automatic test_reset_mid();
    run_xfer(64, 10, 8'h10, 0, 4);
    tests_run++;
    if (m_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre: m_tvalid=%b, want 1", m_tvalid);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_clear: m_tvalid=%b s_tready=%b data=%h, want 0/0/00",
               m_tvalid, s_tready, m_tdata);
    end
    active_i = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    active_i = 1'b0;
    length_i = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    test_reset();
    test_full_packet();
    test_chop();
    test_saturate();
    test_zero_length();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
